// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle chunked add/sub with carry, overflow and zero flags; optional saturation under SEQ_ADDER_SAT_EN
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STEPS = WIDTH / CHUNK;
  localparam int KW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int MSB   = WIDTH - 1;
  localparam logic [KW-1:0] K_LAST = KW'(STEPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;        // already inverted for subtract
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [KW-1:0]    k_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_fin;
  logic             ovf_d;

  // Select the active chunk, add it with the held carry and merge it into the result word
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    sum_d   = sum_q;
    for (int i = 0; i < STEPS; i++) begin
      if (k_q == KW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    for (int i = 0; i < STEPS; i++) begin
      if (k_q == KW'(i)) begin
        sum_d[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
      end
    end
    // Only meaningful on the last chunk, when sum_d holds the complete word
    ovf_d = (a_q[MSB] == b_q[MSB]) && (sum_d[MSB] != a_q[MSB]);
`ifdef SEQ_ADDER_SAT_EN
    // Clamp to the largest positive or most negative value in the operand's direction
    if (ovf_d) begin
      sum_fin = a_q[MSB] ? ~({WIDTH{1'b1}} >> 1) : ({WIDTH{1'b1}} >> 1);
    end else begin
      sum_fin = sum_d;
    end
`else
    sum_fin = sum_d;
`endif
  end

  // Control FSM: capture operands on accepted start, walk the chunks, publish flags on the last one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= sub | cin;
            k_q     <= '0;
            busy_q  <= 1'b1;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= chunk_sum[CHUNK];
          k_q     <= k_q + 1'b1;
          if (k_q == K_LAST) begin
            sum_q   <= sum_fin;
            cout_q  <= chunk_sum[CHUNK];
            ovf_q   <= ovf_d;
            zero_q  <= (sum_fin == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - scoreboard bench for seq_chunk_adder at CHUNK=8, 32 and 1
`timescale 1ns/1ps
module tb_seq_chunk_adder;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  // Reference: whole-word signed/unsigned arithmetic in 64-bit integers
  function automatic res_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                 input logic xs, input logic xc);
    longint sa, sb, ua, ub, r;
    res_t   o;
    sa = longint'($signed(xa));
    sb = longint'($signed(xb));
    ua = longint'(xa);
    ub = longint'(xb);
    if (xs) begin
      r      = sa - sb;
      o.cout = (ua >= ub);
    end else begin
      r      = sa + sb + longint'(xc);
      o.cout = ((ua + ub + longint'(xc)) >= (longint'(1) << W));
    end
    o.ovf = (r > ((longint'(1) << (W-1)) - 1)) || (r < -(longint'(1) << (W-1)));
    o.sum = r[W-1:0];
`ifdef SEQ_ADDER_SAT_EN
    if (o.ovf) o.sum = (r > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
    o.zero = (o.sum == '0);
    return o;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int C  = (g == 0) ? 8 : (g == 1) ? 32 : 1;
    localparam int ST = W / C;

    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub   = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, cout, ovf, zero;
    logic [W-1:0] sum;
    bit           fin   = 1'b0;

    res_t exp_q[$];
    int   due_q[$];
    res_t mon_e;
    int   mon_d;

    seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .sub  (sub),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .busy (busy),
      .done (done),
      .sum  (sum),
      .cout (cout),
      .ovf  (ovf),
      .zero (zero)
    );

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("c%0d unexpected_done", C), 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          mon_d = due_q.pop_front();
          chk($sformatf("c%0d sum", C),     sum,  mon_e.sum);
          chk($sformatf("c%0d cout", C),    cout, mon_e.cout);
          chk($sformatf("c%0d ovf", C),     ovf,  mon_e.ovf);
          chk($sformatf("c%0d zero", C),    zero, mon_e.zero);
          chk($sformatf("c%0d latency", C), cyc,  mon_d);
          chk($sformatf("c%0d busy_at_done", C), busy, 0);
        end
      end
    end

    task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xs, input logic xc);
      int n = 0;
      while (busy && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (busy) chk($sformatf("c%0d issue_timeout", C), 1, 0);
      a = xa; b = xb; sub = xs; cin = xc; start = 1'b1;
      exp_q.push_back(model(xa, xb, xs, xc));
      due_q.push_back(cyc + 1 + ST);
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
      chk($sformatf("c%0d busy_after_accept", C), busy, 1);
    endtask

    task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("c%0d drain", C), exp_q.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
      chk($sformatf("c%0d %s busy", C, tag), busy, 0);
      chk($sformatf("c%0d %s done", C, tag), done, 0);
      chk($sformatf("c%0d %s sum", C, tag),  sum,  0);
      chk($sformatf("c%0d %s cout", C, tag), cout, 0);
      chk($sformatf("c%0d %s ovf", C, tag),  ovf,  0);
      chk($sformatf("c%0d %s zero", C, tag), zero, 0);
    endtask

    initial begin
      int n;
      // Reset with a coincident start request that must be ignored
      rst_n = 1'b0; start = 1'b1; a = '1; b = 32'd1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      check_reset_state("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors from the datapath bring-up list
      issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); drain();
      issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0); drain();
      issue(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1); drain();
      issue(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0); drain();
      issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); drain();
      issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0); drain();
      issue(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1); drain();

      // A start pulse two cycles into an operation must not disturb it
      issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
      @(negedge clk);
      if (busy) begin
        start = 1'b1; a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; sub = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      drain();

      // Start in the done cycle is accepted with no idle gap
      issue(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0, 1'b0);
      n = 0;
      while (!done && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("c%0d b2b_first_done", C), done, 1);
      issue(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0);
      drain();

      // Reset two cycles into an operation abandons it
      issue(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_state("midreset");
      exp_q.delete();
      due_q.delete();
      rst_n = 1'b1;
      repeat (ST + 3) @(negedge clk);

      // Randomized traffic; issue() waiting on busy yields natural back-to-back starts
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        issue(pick(), pick(), 1'($urandom), 1'($urandom));
      end
      drain();
      fin = 1'b1;
    end
  end

  initial begin
    while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && cyc < 60000) @(negedge clk);
    chk("all_configs_finished", {63'd0, cfg[0].fin && cfg[1].fin && cfg[2].fin}, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
